// File: rtl/tcam_match_engine.sv
// Ternary CAM: register-based value/mask/valid store, lowest-address match, search latency 2 cycles.
// One search per cycle with no backpressure; writes are dropped while the init/flush sweep runs.
module tcam_match_engine #(
  parameter int C_TCAM_ADDR_WIDTH = 4,
  parameter int C_TCAM_DATA_WIDTH = 16
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_flush,
  input  logic                         i_we,
  input  logic [C_TCAM_ADDR_WIDTH-1:0] i_wr_addr,
  input  logic                         i_wr_valid,
  input  logic [C_TCAM_DATA_WIDTH-1:0] i_din,
  input  logic [C_TCAM_DATA_WIDTH-1:0] i_data_mask,
  output logic                         o_busy,
  input  logic                         i_cmp_req,
  input  logic [C_TCAM_DATA_WIDTH-1:0] i_cmp_din,
  input  logic [C_TCAM_DATA_WIDTH-1:0] i_cmp_data_mask,
  output logic                         o_cmp_valid,
  output logic                         o_match,
  output logic [C_TCAM_ADDR_WIDTH-1:0] o_match_addr,
  output logic                         o_multiple_match
);

  localparam int AW    = C_TCAM_ADDR_WIDTH;
  localparam int W     = C_TCAM_DATA_WIDTH;
  localparam int DEPTH = 1 << AW;

  typedef enum logic {S_INIT, S_READY} state_t;

  state_t           r_state, w_state_nxt;
  logic [AW-1:0]    r_cnt, w_cnt_nxt;
  logic [W-1:0]     r_value [DEPTH];
  logic [W-1:0]     r_mask  [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] w_hit;
  logic             w_wr_en;

  logic             r_s1_vld;
  logic [DEPTH-1:0] r_s1_hit;
  logic [AW-1:0]    w_enc_addr;
  logic             w_multi;

  logic             r_cmp_valid;
  logic             r_match;
  logic [AW-1:0]    r_match_addr;
  logic             r_multiple_match;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Sweep counter parks at DEPTH-1 once the sweep completes.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_INIT: begin
        if (i_flush) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == {AW{1'b1}}) begin
          w_state_nxt = S_READY;
        end else begin
          w_cnt_nxt = r_cnt + AW'(1);
        end
      end
      S_READY: begin
        if (i_flush) begin
          w_state_nxt = S_INIT;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_INIT;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_busy  = (r_state == S_INIT);
  assign w_wr_en = (r_state == S_READY) & i_we & ~i_flush & ~i_reset;

  always_ff @(posedge i_clk) begin
    if (r_state == S_INIT) begin
      r_valid[r_cnt] <= 1'b0;
    end else if (w_wr_en) begin
      r_value[i_wr_addr] <= i_din;
      r_mask[i_wr_addr]  <= i_data_mask;
      r_valid[i_wr_addr] <= i_wr_valid;
    end
  end

  always_comb begin
    w_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_hit[i] = r_valid[i] &
                 ~|((i_cmp_din ^ r_value[i]) & ~r_mask[i] & ~i_cmp_data_mask);
    end
  end

  // Searches during the sweep still get a result, forced to a miss.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s1_vld <= 1'b0;
      r_s1_hit <= '0;
    end else begin
      r_s1_vld <= i_cmp_req;
      r_s1_hit <= o_busy ? '0 : w_hit;
    end
  end

  always_comb begin
    w_enc_addr = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (r_s1_hit[i]) begin
        w_enc_addr = AW'(i);
      end
    end
  end

  assign w_multi = |(r_s1_hit & (r_s1_hit - DEPTH'(1)));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cmp_valid      <= 1'b0;
      r_match          <= 1'b0;
      r_match_addr     <= '0;
      r_multiple_match <= 1'b0;
    end else begin
      r_cmp_valid <= r_s1_vld;
      if (r_s1_vld) begin
        r_match          <= |r_s1_hit;
        r_match_addr     <= w_enc_addr;
        r_multiple_match <= w_multi;
      end
    end
  end

  assign o_cmp_valid      = r_cmp_valid;
  assign o_match          = r_match;
  assign o_match_addr     = r_match_addr;
  assign o_multiple_match = r_multiple_match;

endmodule

// File: doc/tcam_match_engine.md
# tcam_match_engine

Parametrised, vendor-independent ternary CAM for the switch lookup path, the successor to the core-based TCAM wrapper. It stores value/mask/valid per entry in fabric registers and runs a fully pipelined search, one request per cycle. Each search resolves to the lowest matching address and reports a multiple-match flag. It adds a self-clearing init/flush sequencer and per-entry invalidation, and sits between the header parser and the action table.

## Interface
- C_TCAM_ADDR_WIDTH, 4, entry address width; depth = 2**C_TCAM_ADDR_WIDTH (range 1..8)
- C_TCAM_DATA_WIDTH, 16, key width in bits (range 1..256)
- Clock/reset: one clock; reset is synchronous and active-high.
- CLK  in  1  clock; all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- FLUSH  in  1  single-cycle pulse; invalidates every entry via the init sequence
- WE  in  1  write strobe; ignored while BUSY=1
- WR_ADDR  in  C_TCAM_ADDR_WIDTH  entry to write
- WR_VALID  in  1  1 = install entry, 0 = invalidate entry
- DIN  in  C_TCAM_DATA_WIDTH  stored value
- DATA_MASK  in  C_TCAM_DATA_WIDTH  stored mask; bit=1 means don't care
- BUSY  out  1  high during reset and the init/flush sequence
- CMP_REQ  in  1  search request strobe
- CMP_DIN  in  C_TCAM_DATA_WIDTH  search key
- CMP_DATA_MASK  in  C_TCAM_DATA_WIDTH  per-search mask; bit=1 means don't care
- CMP_VALID  out  1  result-valid strobe
- MATCH  out  1  at least one entry hit
- MATCH_ADDR  out  C_TCAM_ADDR_WIDTH  lowest hitting address; 0 when MATCH=0
- MULTIPLE_MATCH  out  1  two or more entries hit

## Operation
- Storage per entry: value[W], mask[W], valid. Value and mask are not reset; valid is cleared only by the init sequence or by WR_VALID=0.
- Hit rule for entry i: valid[i] & (((CMP_DIN ^ value[i]) & ~mask[i] & ~CMP_DATA_MASK) == 0).
- FSM states:
  - S_INIT: counter clears valid[cnt] one entry per cycle, cnt runs 0..DEPTH-1; BUSY=1. After cnt = DEPTH-1, go to S_READY.
  - S_READY: BUSY=0.
  - RESET entries S_INIT with cnt=0. FLUSH in S_READY does the same. FLUSH in S_INIT restarts cnt at 0.
- Write, S_READY only: at the edge closing the cycle with WE=1, entry WR_ADDR takes DIN, DATA_MASK and valid=WR_VALID. WE during BUSY is dropped with no side effect.
- Search pipeline:
  - Stage 1 registers the DEPTH-bit hit vector plus a valid bit.
  - Stage 2 registers the priority-encoded (lowest index) result, MATCH = |vector, and MULTIPLE_MATCH = more than one bit set.
- CMP_REQ while BUSY=1 is still answered: CMP_VALID=1, MATCH=0, MATCH_ADDR=0, MULTIPLE_MATCH=0. Every request gets exactly one CMP_VALID.
- Outputs hold their last value while CMP_VALID=0.

## Timing
- Reset values: BUSY=1, CMP_VALID=0, MATCH=0, MATCH_ADDR=0, MULTIPLE_MATCH=0; pipeline valid bits cleared; cnt=0.
- Init duration: BUSY stays high for DEPTH cycles after RESET deasserts, then goes low.
- Search latency: CMP_REQ high in cycle N gives CMP_VALID high in cycle N+2. Throughput is 1 per cycle and requests can be back-to-back.
- Write/search same cycle: a search in cycle N sees contents before the cycle-N write. A search in cycle N+1 sees the new contents.
- Write to the same address in consecutive cycles: last write wins.
- FLUSH with WE in the same cycle: FLUSH wins and the write is dropped.
- Searches already in flight when FLUSH is issued complete with their stage-1 vector as captured.
- RESET mid-search: in-flight results are discarded and CMP_VALID=0 on the cycle after RESET.
- Wrap: init cnt stops at DEPTH-1 and does not wrap. MATCH_ADDR width covers DEPTH-1 exactly.

## Test plan
- Reset release: BUSY=1 for exactly 16 cycles (default params), then 0. A search for key 0x0000 mask 0x0000 issued during BUSY → CMP_VALID two cycles later, MATCH=0.
- Write addr 3 = 0x12AB mask 0x00FF, then search 0x1234 mask 0 → MATCH=1, MATCH_ADDR=3, MULTIPLE_MATCH=0. Search 0x1334 → MATCH=0.
- Write addr 5 and addr 9 both = 0xBEEF mask 0; search 0xBEEF → MATCH_ADDR=5, MULTIPLE_MATCH=1. Invalidate addr 5 (WR_VALID=0) → MATCH_ADDR=9, MULTIPLE_MATCH=0.
- Write addr 2 = 0xAAAA and search 0xAAAA in the same cycle → MATCH=0. Repeat the search next cycle → MATCH=1, MATCH_ADDR=2.
- Back-to-back searches for 8 alternating hit/miss keys → 8 consecutive CMP_VALID cycles with results in request order, first result 2 cycles after the first request.
- FLUSH with all entries valid → BUSY=1 for 16 cycles, WE in that window dropped. Afterwards any search with CMP_DATA_MASK=0xFFFF → MATCH=0.
